// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller and its lane aligner.
package dmem_pkg;

    localparam int unsigned OFF_W = 3;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } state_e;

    // Byte lanes of a doubleword touched by an access of the given size at the given offset.
    function automatic logic [7:0] lane_mask(input size_e size, input logic [OFF_W-1:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// little-endian store merge of right-aligned write data into an old word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [63:0]      word,
    input  logic [63:0]      wdata,
    input  logic [OFF_W-1:0] offset,
    input  size_e            size,
    input  logic             unsgn,
    output logic [63:0]      rdata_ext,
    output logic [63:0]      merged_word
);

    logic [63:0] shifted;
    logic [63:0] wshift;
    logic [7:0]  mask;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_B:    rdata_ext = {{56{~unsgn & shifted[7]}},  shifted[7:0]};
            SZ_H:    rdata_ext = {{48{~unsgn & shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata_ext = {{32{~unsgn & shifted[31]}}, shifted[31:0]};
            default: rdata_ext = shifted;
        endcase
    end

    always_comb begin
        mask        = lane_mask(size, offset);
        wshift      = wdata << {offset, 3'b000};
        merged_word = word;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i]) begin
                merged_word[8*i +: 8] = wshift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// LSU-to-SRAM data-memory controller: B/H/W/D loads and stores, read-modify-write
// for sub-doubleword stores. Define DMEM_PERF_CNT_EN to build the saturating perf counters.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter  int unsigned XLEN  = 64,
    parameter  int unsigned DEPTH = 262144,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic            sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [XLEN-1:0] sram_data_in,
    input  logic [XLEN-1:0] sram_data_out,
    output logic [31:0]     perf_loads,
    output logic [31:0]     perf_stores,
    output logic [31:0]     perf_faults
);

    state_e          state, state_d;
    size_e           req_sz;
    logic            misaligned, out_of_range, req_fault, accept, req_dstore;

    logic            r_we;
    logic [AW-1:0]   r_word;
    logic [OFF_W-1:0] r_off;
    size_e           r_size;
    logic            r_unsgn;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] wbuf;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;

    logic [XLEN-1:0] rdata_ext, merged_word;

    assign req_sz = size_e'(req_size);

    always_comb begin
        case (req_sz)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign out_of_range = |req_addr[XLEN-1:AW+OFF_W];
    assign req_fault    = misaligned | out_of_range;
    assign accept       = req_valid & (state == IDLE);
    assign req_dstore   = req_we & (req_sz == SZ_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (req_dstore) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = r_we ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A faulting request leaves the SRAM-facing registers untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_word  <= '0;
            r_off   <= '0;
            r_size  <= SZ_B;
            r_unsgn <= 1'b0;
            r_wdata <= '0;
            wbuf    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            r_we    <= req_we;
            r_off   <= req_addr[OFF_W-1:0];
            r_size  <= req_sz;
            r_unsgn <= req_unsigned;
            r_wdata <= req_wdata;
            rdata_q <= '0;
            fault_q <= req_fault;
            if (!req_fault) begin
                r_word <= req_addr[AW+OFF_W-1:OFF_W];
                if (req_dstore) begin
                    wbuf <= req_wdata;
                end
            end
        end else if (state == CAPTURE) begin
            if (r_we) begin
                wbuf <= merged_word;
            end else begin
                rdata_q <= rdata_ext;
            end
        end
    end

    dmem_lane_align u_align (
        .word        (sram_data_out),
        .wdata       (r_wdata),
        .offset      (r_off),
        .size        (r_size),
        .unsgn       (r_unsgn),
        .rdata_ext   (rdata_ext),
        .merged_word (merged_word)
    );

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_rdata   = rdata_q;
    assign resp_fault   = fault_q;
    assign sram_we      = (state == WRITE);
    assign sram_addr    = r_word;
    assign sram_data_in = wbuf;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] cnt_loads, cnt_stores, cnt_faults;
    logic        done;

    assign done = (state == RESP) & resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_loads  <= '0;
            cnt_stores <= '0;
            cnt_faults <= '0;
        end else if (done) begin
            if (fault_q) begin
                if (cnt_faults != '1) cnt_faults <= cnt_faults + 32'd1;
            end else if (r_we) begin
                if (cnt_stores != '1) cnt_stores <= cnt_stores + 32'd1;
            end else begin
                if (cnt_loads != '1) cnt_loads <= cnt_loads + 32'd1;
            end
        end
    end

    assign perf_loads  = cnt_loads;
    assign perf_stores = cnt_stores;
    assign perf_faults = cnt_faults;
`else
    assign perf_loads  = '0;
    assign perf_stores = '0;
    assign perf_faults = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-addressed reference memory model,
// directed boundary vectors, randomized traffic, stall, back-to-back and reset-in-write.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 262144;
    localparam int unsigned AW    = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [63:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic [63:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_rdata;
    logic          resp_fault;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_data_in;
    logic [63:0]   sram_data_out;
    logic [31:0]   perf_loads, perf_stores, perf_faults;

    logic [63:0]   smem [0:DEPTH-1];
    int            we_cnt = 0;
    int            total = 0;
    int            bad = 0;

    logic [7:0]    refmem [longint unsigned];
    int            exp_loads = 0, exp_stores = 0, exp_faults = 0;

    typedef struct {
        bit          we;
        logic [63:0] a;
        int          sz;
        bit          uns;
        logic [63:0] wd;
    } vec_t;

    dmem_ctrl #(.XLEN(64), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out),
        .perf_loads    (perf_loads),
        .perf_stores   (perf_stores),
        .perf_faults   (perf_faults)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: registered read data, write on enabled edge.
    always @(posedge clk) begin
        if (sram_we) smem[sram_addr] <= sram_data_in;
        sram_data_out <= smem[sram_addr];
        if (sram_we) we_cnt <= we_cnt + 1;
    end

    function automatic logic [7:0] rbyte(input longint unsigned a);
        return refmem.exists(a) ? refmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_perf(input int sel);
`ifdef DMEM_PERF_CNT_EN
        return (sel == 0) ? 32'(exp_loads) : (sel == 1) ? 32'(exp_stores) : 32'(exp_faults);
`else
        return (sel >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Reference: byte memory, latency and SRAM-write count from the access class.
    task automatic model(input bit we, input longint unsigned a, input int sz, input bit uns,
                         input logic [63:0] wd, output logic [63:0] er, output bit ef,
                         output int el, output int ew);
        int n;
        n  = 1 << sz;
        er = '0;
        ew = 0;
        ef = ((a % longint'(n)) != 0) || (a >= 64'(DEPTH) * 64'd8);
        if (ef) begin
            el = 1;
            exp_faults++;
        end else if (we) begin
            for (int i = 0; i < n; i++) refmem[a + longint'(i)] = wd[8*i +: 8];
            el = (sz == 3) ? 2 : 4;
            ew = 1;
            exp_stores++;
        end else begin
            for (int i = 0; i < n; i++) er = er | (64'(rbyte(a + longint'(i))) << (8*i));
            if (!uns && n < 8 && er[8*n-1]) er = er - (64'd1 << (8*n));
            el = 3;
            exp_loads++;
        end
    endtask

    task automatic send(input bit we, input logic [63:0] a, input int sz, input bit uns,
                        input logic [63:0] wd);
        req_we       = we;
        req_addr     = a;
        req_size     = 2'(sz);
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rst_in sram_we: got %b want 0", sram_we); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst req_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst resp_valid: got %b want 0", resp_valid); end
        total++; if (resp_rdata !== 64'd0) begin bad++; $display("FAIL rst resp_rdata: got %h want 0", resp_rdata); end
        total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL rst resp_fault: got %b want 0", resp_fault); end
        total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rst sram_we: got %b want 0", sram_we); end
        total++; if (sram_addr !== '0) begin bad++; $display("FAIL rst sram_addr: got %h want 0", sram_addr); end
        total++; if (sram_data_in !== 64'd0) begin bad++; $display("FAIL rst sram_data_in: got %h want 0", sram_data_in); end
        total++; if ({perf_loads, perf_stores, perf_faults} !== 96'd0) begin
            bad++; $display("FAIL rst perf: got %0d/%0d/%0d want 0/0/0", perf_loads, perf_stores, perf_faults);
        end
    endtask

    task automatic test_directed();
        vec_t        vt [20];
        logic [63:0] last, er, rd;
        bit          ef;
        logic        f;
        int          el, ew, lat, wb;
        last   = 64'(DEPTH - 1) * 64'd8;
        vt[0]  = '{1'b1, 64'h10, 3, 1'b0, 64'h0123456789ABCDEF};
        vt[1]  = '{1'b0, 64'h10, 3, 1'b0, 64'h0};
        vt[2]  = '{1'b1, 64'h13, 0, 1'b0, 64'hDEADBEEFCAFE12FF};
        vt[3]  = '{1'b0, 64'h10, 3, 1'b0, 64'h0};
        vt[4]  = '{1'b0, 64'h13, 0, 1'b0, 64'h0};
        vt[5]  = '{1'b0, 64'h13, 0, 1'b1, 64'h0};
        vt[6]  = '{1'b0, 64'h12, 1, 1'b0, 64'h0};
        vt[7]  = '{1'b0, 64'h11, 1, 1'b0, 64'h0};
        vt[8]  = '{1'b0, 64'h14, 2, 1'b0, 64'h0};
        vt[9]  = '{1'b0, 64'h16, 2, 1'b0, 64'h0};
        vt[10] = '{1'b1, 64'h16, 2, 1'b0, 64'h5555AAAA5555AAAA};
        vt[11] = '{1'b0, 64'(DEPTH) * 64'd8, 3, 1'b0, 64'h0};
        vt[12] = '{1'b1, last, 3, 1'b0, 64'hFEDCBA9876543210};
        vt[13] = '{1'b0, last, 3, 1'b0, 64'h0};
        vt[14] = '{1'b0, last + 64'd4, 2, 1'b1, 64'h0};
        vt[15] = '{1'b1, last + 64'd6, 1, 1'b0, 64'h123456789ABCBEEF};
        vt[16] = '{1'b0, last, 3, 1'b0, 64'h0};
        vt[17] = '{1'b0, last + 64'd4, 2, 1'b0, 64'h0};
        vt[18] = '{1'b0, 64'h8000000000000000, 0, 1'b0, 64'h0};
        vt[19] = '{1'b1, 64'h10, 3, 1'b1, 64'h0123456789ABCDEF};
        for (int k = 0; k < 20; k++) begin
            model(vt[k].we, vt[k].a, vt[k].sz, vt[k].uns, vt[k].wd, er, ef, el, ew);
            wb = we_cnt;
            send(vt[k].we, vt[k].a, vt[k].sz, vt[k].uns, vt[k].wd);
            wait_resp(lat);
            rd = resp_rdata;
            f  = resp_fault;
            ack();
            total++; if (lat !== el) begin bad++; $display("FAIL dir%0d latency: got %0d want %0d", k, lat, el); end
            total++; if (f !== ef) begin bad++; $display("FAIL dir%0d fault: got %b want %b", k, f, ef); end
            total++; if (rd !== er) begin bad++; $display("FAIL dir%0d rdata: got %h want %h", k, rd, er); end
            total++; if ((we_cnt - wb) !== ew) begin bad++; $display("FAIL dir%0d sram writes: got %0d want %0d", k, we_cnt - wb, ew); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, wd, er, rd;
        bit          ef, we, uns;
        logic        f;
        int          el, ew, lat, wb, sz, r;
        for (int k = 0; k < 316; k++) begin
            wd = {$urandom, $urandom};
            if (k < 16) begin
                a = 64'(k) * 64'd8; we = 1'b1; sz = 3; uns = 1'b0;
            end else begin
                r   = $urandom_range(0, 19);
                we  = 1'($urandom_range(0, 1));
                sz  = $urandom_range(0, 3);
                uns = 1'($urandom_range(0, 1));
                a   = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
                if (r == 16 || r == 17) a = 64'(DEPTH - 1) * 64'd8 + 64'($urandom_range(0, 7));
                if (r == 18) a = 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 4095));
                if (r == 19) a = a | (64'd1 << $urandom_range(21, 63));
            end
            model(we, a, sz, uns, wd, er, ef, el, ew);
            wb = we_cnt;
            send(we, a, sz, uns, wd);
            wait_resp(lat);
            rd = resp_rdata;
            f  = resp_fault;
            ack();
            total++; if (lat !== el) begin bad++; $display("FAIL rnd%0d latency: got %0d want %0d", k, lat, el); end
            total++; if (f !== ef) begin bad++; $display("FAIL rnd%0d fault: got %b want %b", k, f, ef); end
            total++; if (rd !== er) begin bad++; $display("FAIL rnd%0d rdata: got %h want %h", k, rd, er); end
            total++; if ((we_cnt - wb) !== ew) begin bad++; $display("FAIL rnd%0d sram writes: got %0d want %0d", k, we_cnt - wb, ew); end
        end
        total++; if (perf_loads !== exp_perf(0)) begin bad++; $display("FAIL perf_loads: got %0d want %0d", perf_loads, exp_perf(0)); end
        total++; if (perf_stores !== exp_perf(1)) begin bad++; $display("FAIL perf_stores: got %0d want %0d", perf_stores, exp_perf(1)); end
        total++; if (perf_faults !== exp_perf(2)) begin bad++; $display("FAIL perf_faults: got %0d want %0d", perf_faults, exp_perf(2)); end
    endtask

    task automatic test_hold();
        logic [63:0] er;
        bit          ef;
        int          el, ew, lat;
        model(1'b0, 64'h10, 3, 1'b0, 64'h0, er, ef, el, ew);
        send(1'b0, 64'h10, 3, 1'b0, 64'h0);
        wait_resp(lat);
        total++; if (lat !== el) begin bad++; $display("FAIL hold latency: got %0d want %0d", lat, el); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL hold%0d resp_valid: got %b want 1", c, resp_valid); end
            total++; if (resp_rdata !== er) begin bad++; $display("FAIL hold%0d rdata: got %h want %h", c, resp_rdata, er); end
            total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL hold%0d fault: got %b want 0", c, resp_fault); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold%0d req_ready: got %b want 0", c, req_ready); end
        end
        ack();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hold release req_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL hold release resp_valid: got %b want 0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] er, wd;
        bit          ef;
        int          el, ew, lat, wb;
        model(1'b0, 64'h14, 2, 1'b0, 64'h0, er, ef, el, ew);
        send(1'b0, 64'h14, 2, 1'b0, 64'h0);
        wait_resp(lat);
        total++; if (resp_rdata !== er) begin bad++; $display("FAIL b2b load rdata: got %h want %h", resp_rdata, er); end
        wd = {$urandom, $urandom};
        model(1'b1, 64'h16, 1, 1'b0, wd, er, ef, el, ew);
        req_we = 1'b1; req_addr = 64'h16; req_size = 2'd1; req_unsigned = 1'b0; req_wdata = wd;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b early accept req_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL b2b early resp_valid: got %b want 0", resp_valid); end
        wb = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b accept req_ready: got %b want 0", req_ready); end
        wait_resp(lat);
        ack();
        total++; if (lat !== el) begin bad++; $display("FAIL b2b store latency: got %0d want %0d", lat, el); end
        total++; if ((we_cnt - wb) !== ew) begin bad++; $display("FAIL b2b sram writes: got %0d want %0d", we_cnt - wb, ew); end
        model(1'b0, 64'h10, 3, 1'b0, 64'h0, er, ef, el, ew);
        send(1'b0, 64'h10, 3, 1'b0, 64'h0);
        wait_resp(lat);
        total++; if (resp_rdata !== er) begin bad++; $display("FAIL b2b merge rdata: got %h want %h", resp_rdata, er); end
        ack();
    endtask

    task automatic test_reset_write();
        logic [63:0] old, er;
        bit          ef;
        int          el, ew, lat, n;
        old = smem[3];
        send(1'b1, 64'(3 * 8 + 5), 0, 1'b0, {$urandom, $urandom});
        n = 0;
        while (sram_we !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (sram_we !== 1'b1) begin bad++; $display("FAIL rstw reach WRITE: sram_we got %b want 1", sram_we); end
        #2 rst = 1'b1;
        #1;
        total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rstw sram_we drop: got %b want 0", sram_we); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstw req_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstw resp_valid: got %b want 0", resp_valid); end
        @(posedge clk); #1;
        total++; if (smem[3] !== old) begin bad++; $display("FAIL rstw sram word: got %h want %h", smem[3], old); end
        @(negedge clk) rst = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_faults = 0;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstw release req_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstw release resp_valid: got %b want 0", resp_valid); end
        total++; if ({perf_loads, perf_stores, perf_faults} !== 96'd0) begin
            bad++; $display("FAIL rstw perf: got %0d/%0d/%0d want 0/0/0", perf_loads, perf_stores, perf_faults);
        end
        model(1'b0, 64'(3 * 8), 3, 1'b0, 64'h0, er, ef, el, ew);
        send(1'b0, 64'(3 * 8), 3, 1'b0, 64'h0);
        wait_resp(lat);
        total++; if (resp_rdata !== er) begin bad++; $display("FAIL rstw word readback: got %h want %h", resp_rdata, er); end
        ack();
        total++; if (perf_loads !== exp_perf(0)) begin bad++; $display("FAIL rstw perf_loads: got %0d want %0d", perf_loads, exp_perf(0)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
